// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg
//   Shared definitions for the CPU register-bank responder: register
//   offsets (relative to the block's base word address), the count of
//   fixed registers ahead of the scratch bank, and the default ID value.
package cpu_reg_pkg;

    localparam int REG_ID         = 0;
    localparam int REG_CTRL       = 1;
    localparam int REG_CMD        = 2;
    localparam int REG_STATUS     = 3;
    localparam int REG_IRQ_EN     = 4;
    localparam int REG_TICK       = 5;
    localparam int REG_SCRATCH0   = 6;

    // Registers that precede the scratch bank.
    localparam int NUM_FIXED_REGS = 6;

    localparam logic [31:0] DEFAULT_ID = 32'hC0DE_0001;

endpackage

// File: rtl/cpu_reg_edge.sv
// cpu_reg_edge
//   Rising-edge detector. Keeps a registered copy of the input and flags
//   the cycle where the input is high but was low on the previous clock.
//   The delay register clears in reset, so an input already high when
//   reset releases is reported as an edge on the first cycle out of reset.
//
// Ports
//   iclk    in   clock
//   irst    in   synchronous reset, active-low
//   isig    in   level input
//   opulse  out  high for the first cycle isig is seen high (combinational)
module cpu_reg_edge (
    input  logic iclk,
    input  logic irst,
    input  logic isig,
    output logic opulse
);

    logic r_sig_q;

    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= isig;
        end
    end

    assign opulse = isig & ~r_sig_q;

endmodule

// File: rtl/cpu_reg_resp.sv
// cpu_reg_resp
//   Register-bank responder for the simulation CPU bus master. Decodes the
//   word address, commits one write per rising edge of iwr, returns
//   registered read data every cycle ird is high, drives the CTRL register
//   and a CMD start pulse, and collects sticky STATUS events into an IRQ.
//
//   Offset map: 0 ID (RO), 1 CTRL (RW), 2 CMD (WO, reads 0), 3 STATUS
//   (sticky, W1C), 4 IRQ_EN (RW), 5 TICK (free-running, write clears),
//   6..5+NUM_SCRATCH SCRATCH (RW).
//
// Ports
//   iclk         in   clock
//   irst         in   synchronous reset, active-low
//   iaddr        in   word address from master
//   idata        in   write data from master
//   iwr          in   write strobe (level, one commit per rising edge)
//   ird          in   read strobe (level, samples every cycle high)
//   odata        out  registered read data
//   ohit         out  registered: last sampled read address was mapped
//   octrl        out  CTRL register
//   ostart       out  one-cycle pulse on CMD write with bit0 set
//   istatus_set  in   per-bit sticky STATUS set pulses
//   oirq         out  registered OR of STATUS & IRQ_EN
module cpu_reg_resp
    import cpu_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]           ID_VALUE    = DEFAULT_ID,
    parameter int                    NUM_SCRATCH = 4
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  iwr,
    input  logic                  ird,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ohit,
    output logic [DATA_WIDTH-1:0] octrl,
    output logic                  ostart,
    input  logic [DATA_WIDTH-1:0] istatus_set,
    output logic                  oirq
);

    localparam int                    NUM_REGS = NUM_FIXED_REGS + NUM_SCRATCH;
    localparam logic [DATA_WIDTH-1:0] L_ID     = DATA_WIDTH'(ID_VALUE);

    logic [DATA_WIDTH-1:0] r_odata;
    logic                  r_ohit;
    logic [DATA_WIDTH-1:0] r_ctrl;
    logic                  r_ostart;
    logic [DATA_WIDTH-1:0] r_status;
    logic [DATA_WIDTH-1:0] r_irq_en;
    logic [DATA_WIDTH-1:0] r_tick;
    logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];
    logic                  r_oirq;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_hit;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_cmd;
    logic                  w_wr_status;
    logic                  w_wr_irq_en;
    logic                  w_wr_tick;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Offset wraps for addresses below the base, so those land far above
    // the map and decode as unmapped.
    assign w_offset = iaddr - BASE_ADDR;
    assign w_hit    = (w_offset < ADDR_WIDTH'(NUM_REGS));

    cpu_reg_edge u_wr_edge (
        .iclk   (iclk),
        .irst   (irst),
        .isig   (iwr),
        .opulse (w_wr)
    );

    assign w_wr_ctrl   = w_wr && (w_offset == ADDR_WIDTH'(REG_CTRL));
    assign w_wr_cmd    = w_wr && (w_offset == ADDR_WIDTH'(REG_CMD));
    assign w_wr_status = w_wr && (w_offset == ADDR_WIDTH'(REG_STATUS));
    assign w_wr_irq_en = w_wr && (w_offset == ADDR_WIDTH'(REG_IRQ_EN));
    assign w_wr_tick   = w_wr && (w_offset == ADDR_WIDTH'(REG_TICK));
    assign w_clr       = w_wr_status ? idata : '0;

    // Read mux works off current register contents, so a read sampled on a
    // write-commit cycle returns the pre-write value.
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_offset)
                ADDR_WIDTH'(REG_ID):     w_rdata = L_ID;
                ADDR_WIDTH'(REG_CTRL):   w_rdata = r_ctrl;
                ADDR_WIDTH'(REG_CMD):    w_rdata = '0;
                ADDR_WIDTH'(REG_STATUS): w_rdata = r_status;
                ADDR_WIDTH'(REG_IRQ_EN): w_rdata = r_irq_en;
                ADDR_WIDTH'(REG_TICK):   w_rdata = r_tick;
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (w_offset == ADDR_WIDTH'(REG_SCRATCH0 + i)) begin
                            w_rdata = r_scratch[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_odata  <= '0;
            r_ohit   <= 1'b0;
            r_ctrl   <= '0;
            r_ostart <= 1'b0;
            r_status <= '0;
            r_irq_en <= '0;
            r_tick   <= '0;
            r_oirq   <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            if (ird) begin
                r_odata <= w_rdata;
                r_ohit  <= w_hit;
            end

            if (w_wr_ctrl) begin
                r_ctrl <= idata;
            end
            if (w_wr_irq_en) begin
                r_irq_en <= idata;
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_wr && (w_offset == ADDR_WIDTH'(REG_SCRATCH0 + i))) begin
                    r_scratch[i] <= idata;
                end
            end

            r_ostart <= w_wr_cmd & idata[0];

            // Set is OR'd in after the clear mask, so set wins on a bit.
            r_status <= (r_status & ~w_clr) | istatus_set;

            r_tick   <= w_wr_tick ? '0 : r_tick + DATA_WIDTH'(1);

            r_oirq   <= |(r_status & r_irq_en);
        end
    end

    assign odata  = r_odata;
    assign ohit   = r_ohit;
    assign octrl  = r_ctrl;
    assign ostart = r_ostart;
    assign oirq   = r_oirq;

endmodule

// File: tb/tb_cpu_reg_resp.sv
module tb_cpu_reg_resp;

    localparam logic [15:0] BASE = 16'h0100;

    logic        iclk;
    logic        irst;
    logic [15:0] iaddr;
    logic [31:0] idata;
    logic        iwr;
    logic        ird;
    logic [31:0] odata;
    logic        ohit;
    logic [31:0] octrl;
    logic        ostart;
    logic [31:0] istatus_set;
    logic        oirq;

    // Narrow instance used only to observe TICK wrap in reachable time.
    logic [15:0] iaddr8;
    logic [7:0]  idata8;
    logic [7:0]  istatus8;
    logic [7:0]  odata8;
    logic        ohit8;
    logic [7:0]  octrl8;
    logic        ostart8;
    logic        oirq8;

    cpu_reg_resp #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .ID_VALUE   (32'hC0DE_0001),
        .NUM_SCRATCH(4)
    ) u_dut (
        .iclk        (iclk),
        .irst        (irst),
        .iaddr       (iaddr),
        .idata       (idata),
        .iwr         (iwr),
        .ird         (ird),
        .odata       (odata),
        .ohit        (ohit),
        .octrl       (octrl),
        .ostart      (ostart),
        .istatus_set (istatus_set),
        .oirq        (oirq)
    );

    cpu_reg_resp #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .BASE_ADDR  (BASE),
        .ID_VALUE   (32'hC0DE_0001),
        .NUM_SCRATCH(1)
    ) u_dut8 (
        .iclk        (iclk),
        .irst        (irst),
        .iaddr       (iaddr8),
        .idata       (idata8),
        .iwr         (1'b0),
        .ird         (1'b1),
        .odata       (odata8),
        .ohit        (ohit8),
        .octrl       (octrl8),
        .ostart      (ostart8),
        .istatus_set (istatus8),
        .oirq        (oirq8)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic [31:0] d;
        logic        h;
        string       name;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rd_q = 1'b0;
    logic        tick_clr = 1'b0;
    logic [31:0] tb_tick = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected TICK value held by the DUT right now.
    always @(posedge iclk) begin
        if (!irst || tick_clr) tb_tick <= '0;
        else                   tb_tick <= tb_tick + 32'd1;
        rd_q <= ird;
    end

    // Monitor: a read sampled on the last edge means odata/ohit are new.
    always @(negedge iclk) begin
        if (rd_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_read_response", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_data"}, odata, mon_e.d);
                check({mon_e.name, "_hit"}, {31'd0, ohit}, {31'd0, mon_e.h});
            end
        end
    end

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input logic hit,
                           input string name);
        exp_t e;
        e.d = exp; e.h = hit; e.name = name;
        sb_q.push_back(e);
        iaddr = addr;
        ird   = 1'b1;
        @(negedge iclk);
        ird   = 1'b0;
    endtask

    task automatic do_read_tick(input string name);
        do_read(BASE + 16'd5, tb_tick, 1'b1, name);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input int hold);
        iaddr    = addr;
        idata    = data;
        iwr      = 1'b1;
        tick_clr = (addr == BASE + 16'd5);
        @(negedge iclk);
        tick_clr = 1'b0;
        repeat (hold - 1) @(negedge iclk);
        iwr = 1'b0;
        @(negedge iclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        irst = 1'b0; iwr = 1'b0; ird = 1'b0; iaddr = '0; idata = '0; istatus_set = '0;
        iaddr8 = BASE + 16'd5; idata8 = '0; istatus8 = '0;
        repeat (3) @(negedge iclk);
        check("rst_odata",  odata,          32'd0);
        check("rst_ohit",   {31'd0, ohit},  32'd0);
        check("rst_octrl",  octrl,          32'd0);
        check("rst_ostart", {31'd0, ostart},32'd0);
        check("rst_oirq",   {31'd0, oirq},  32'd0);
        irst = 1'b1;

        do_read(BASE + 16'd0, 32'hC0DE_0001, 1'b1, "rd_id");
        do_read(BASE + 16'd1, 32'h0,         1'b1, "rd_ctrl_rst");
        do_read(BASE + 16'd3, 32'h0,         1'b1, "rd_status_rst");
        do_read(BASE + 16'd5, 32'd3,         1'b1, "rd_tick_first");

        // CTRL write held 3 cycles; changing idata mid-hold must not recommit.
        iaddr = BASE + 16'd1; idata = 32'hA5A5_5A5A; iwr = 1'b1;
        @(negedge iclk);
        check("ctrl_after_rise", octrl, 32'hA5A5_5A5A);
        idata = 32'hDEAD_BEEF;
        repeat (2) @(negedge iclk);
        check("ctrl_single_commit", octrl, 32'hA5A5_5A5A);
        iwr = 1'b0;
        @(negedge iclk);
        do_read(BASE + 16'd1, 32'hA5A5_5A5A, 1'b1, "rd_ctrl");
        @(negedge iclk);
        check("odata_hold", odata, 32'hA5A5_5A5A);

        // CMD start pulse.
        iaddr = BASE + 16'd2; idata = 32'h1; iwr = 1'b1;
        @(negedge iclk);
        check("ostart_pulse", {31'd0, ostart}, 32'd1);
        iwr = 1'b0;
        @(negedge iclk);
        check("ostart_one_cycle", {31'd0, ostart}, 32'd0);
        iaddr = BASE + 16'd2; idata = 32'h2; iwr = 1'b1;
        @(negedge iclk);
        check("ostart_bit0_clear", {31'd0, ostart}, 32'd0);
        iwr = 1'b0;
        @(negedge iclk);
        do_read(BASE + 16'd2, 32'h0, 1'b1, "rd_cmd");

        // STATUS / IRQ.
        do_write(BASE + 16'd4, 32'h4, 1);
        istatus_set = 32'h5;
        @(negedge iclk);
        istatus_set = 32'h0;
        do_read(BASE + 16'd3, 32'h5, 1'b1, "rd_status_set");
        check("oirq_set", {31'd0, oirq}, 32'd1);
        iaddr = BASE + 16'd3; idata = 32'h4; iwr = 1'b1; istatus_set = 32'h4;
        @(negedge iclk);
        iwr = 1'b0; istatus_set = 32'h0;
        @(negedge iclk);
        do_read(BASE + 16'd3, 32'h5, 1'b1, "rd_status_set_wins");
        do_write(BASE + 16'd3, 32'h4, 1);
        do_read(BASE + 16'd3, 32'h1, 1'b1, "rd_status_w1c");
        check("oirq_cleared", {31'd0, oirq}, 32'd0);

        // Scratch and unmapped accesses.
        do_write(BASE + 16'd6, 32'h1111_1111, 2);
        do_write(BASE + 16'd9, 32'h4444_4444, 1);
        do_read(BASE + 16'd6,  32'h1111_1111, 1'b1, "rd_scratch0");
        do_read(BASE + 16'd9,  32'h4444_4444, 1'b1, "rd_scratch3");
        do_read(BASE + 16'd10, 32'h0,         1'b0, "rd_unmapped_hi");
        do_read(BASE - 16'd1,  32'h0,         1'b0, "rd_unmapped_lo");
        do_write(BASE + 16'd10, 32'hFFFF_FFFF, 1);
        do_write(BASE - 16'd1,  32'hFFFF_FFFF, 1);
        do_write(BASE + 16'd0,  32'hFFFF_FFFF, 1);
        do_read(BASE + 16'd0, 32'hC0DE_0001, 1'b1, "rd_id_after_wr");
        do_read(BASE + 16'd1, 32'hA5A5_5A5A, 1'b1, "rd_ctrl_after_unmapped");
        do_read(BASE + 16'd4, 32'h4,         1'b1, "rd_irqen_after_unmapped");
        do_read(BASE + 16'd6, 32'h1111_1111, 1'b1, "rd_scratch0_after_unmapped");
        do_read(BASE + 16'd9, 32'h4444_4444, 1'b1, "rd_scratch3_after_unmapped");

        // TICK write-clear beats increment; read the next cycle sees 0.
        iaddr = BASE + 16'd5; idata = 32'h1234; iwr = 1'b1; tick_clr = 1'b1;
        @(negedge iclk);
        tick_clr = 1'b0; iwr = 1'b0;
        do_read(BASE + 16'd5, 32'h0, 1'b1, "rd_tick_cleared");
        do_read(BASE + 16'd5, 32'h1, 1'b1, "rd_tick_after_clear");
        repeat (4) @(negedge iclk);
        do_read_tick("rd_tick_model");

        // Read on the write-commit cycle returns the old value.
        iaddr = BASE + 16'd6; idata = 32'h55; iwr = 1'b1; ird = 1'b1;
        begin
            exp_t e;
            e.d = 32'h1111_1111; e.h = 1'b1; e.name = "rd_during_write";
            sb_q.push_back(e);
        end
        @(negedge iclk);
        iwr = 1'b0; ird = 1'b0;
        do_read(BASE + 16'd6, 32'h55, 1'b1, "rd_after_write");

        // Reset in the middle of a held write; re-commits on release.
        iaddr = BASE + 16'd1; idata = 32'h1234_5678; iwr = 1'b1; irst = 1'b0;
        repeat (2) @(negedge iclk);
        check("ctrl_in_reset", octrl, 32'h0);
        check("odata_in_reset", odata, 32'h0);
        irst = 1'b1;
        @(negedge iclk);
        check("ctrl_recommit", octrl, 32'h1234_5678);
        iwr = 1'b0;
        @(negedge iclk);
        do_read(BASE + 16'd1, 32'h1234_5678, 1'b1, "rd_ctrl_recommit");
        do_read(BASE + 16'd6, 32'h0,         1'b1, "rd_scratch_after_rst");
        do_read(BASE + 16'd4, 32'h0,         1'b1, "rd_irqen_after_rst");
        do_read_tick("rd_tick_after_rst");

        // TICK wrap on the 8-bit instance (continuously reading TICK).
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge iclk);
            if (odata8 == 8'hFF) found = 1'b1;
        end
        check("tick8_reaches_ff", {31'd0, found}, 32'd1);
        if (found) begin
            @(negedge iclk);
            check("tick8_wrap", {24'd0, odata8}, 32'h0);
            check("tick8_hit", {31'd0, ohit8}, 32'd1);
        end

        repeat (2) @(negedge iclk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_reg_resp.md
# cpu_reg_resp

Register-bank responder for the simulation CPU bus master. It decodes the master's address/data/strobe bus, holds a small control/status register map, and returns read data to the master's data input. It sits between the CPU bus and the protocol datapath, driving control outputs and collecting sticky status events.

## Interface
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 32, bus and register width (≥ 8)
- BASE_ADDR, 0, word address of register 0
- ID_VALUE, 32'hC0DE_0001, constant returned by ID register (truncated to DATA_WIDTH)
- NUM_SCRATCH, 4, number of scratch registers (1..8)

- iclk  in  1  clock
- irst  in  1  reset, synchronous, active-low
- iaddr  in  ADDR_WIDTH  word address from master
- idata  in  DATA_WIDTH  write data from master
- iwr  in  1  write strobe, level, held ≥1 cycle per transaction
- ird  in  1  read strobe, level, held ≥1 cycle per transaction
- odata  out  DATA_WIDTH  registered read data to master
- ohit  out  1  registered: last sampled read address decoded to a register
- octrl  out  DATA_WIDTH  CTRL register contents
- ostart  out  1  one-cycle pulse from CMD write
- istatus_set  in  DATA_WIDTH  per-bit sticky set events, one-cycle pulses
- oirq  out  1  registered OR of (STATUS & IRQ_EN)

## Operation
- Offset = iaddr − BASE_ADDR (ADDR_WIDTH-bit unsigned); hit iff offset < 6+NUM_SCRATCH.
- Map (offset): 0 ID (RO); 1 CTRL (RW); 2 CMD (WO, reads 0; write with bit0=1 → ostart); 3 STATUS (sticky, write-1-to-clear); 4 IRQ_EN (RW); 5 TICK (free-running counter, RO, any write clears to 0); 6..5+NUM_SCRATCH SCRATCH (RW).
- Write commit: exactly once per iwr rising edge (iwr & ~iwr_q); strobe held N cycles still commits once. iaddr/idata sampled on the edge cycle.
- Writes to ID, unmapped offsets: ignored.
- Read: every cycle with ird=1, odata ← selected register, ohit ← hit; unmapped → odata 0, ohit 0. With ird=0 odata/ohit hold.
- Simultaneous write commit and read: read returns pre-write value.
- STATUS next = (STATUS & ~clr) | istatus_set; set wins over clear on same bit same cycle.
- TICK increments every cycle, wraps all-ones → 0; write-clear takes precedence over increment.
- oirq ← |(STATUS & IRQ_EN), one-cycle lag.

## Timing
- Reset (irst=0 at edge): odata, ohit, octrl, ostart, oirq, STATUS, IRQ_EN, TICK, SCRATCH, iwr_q all 0. iwr held high across reset release counts as a new rising edge on the first cycle out of reset.
- Read latency: odata valid 1 cycle after ird first sampled high; master holding ird ≥1 cycle before sampling sees correct data.
- Write visibility: CTRL/IRQ_EN/SCRATCH update at the edge-cycle clock; octrl changes 1 cycle after iwr rise; ostart high exactly the cycle after iwr rise.
- STATUS bit visible to read 1 cycle after istatus_set; oirq 2 cycles after istatus_set.
- TICK reads value at cycle of ird sample.

## Structure
- Shared package cpu_reg_pkg: register offset constants (REG_ID, REG_CTRL, REG_CMD, REG_STATUS, REG_IRQ_EN, REG_TICK, REG_SCRATCH0), default ID value.
- One sub-module natural: cpu_reg_edge (rising-edge detector with registered delay, reset to 0), used for iwr.
- Read mux, write decode, STATUS/TICK logic in top level.

## Test plan
- Reset then read offsets 0,1,3,5 (BASE_ADDR=0x100, iaddr 0x100…) → odata 0xC0DE0001, 0, 0, TICK count; ohit=1; all outputs 0 during reset.
- Write CTRL=0xA5A5_5A5A with iwr held 3 cycles → octrl 0xA5A5_5A5A one cycle after rise; readback matches; single commit (monitor write counter = 1).
- Write CMD=0x1 → ostart high exactly 1 cycle; CMD=0x2 → no pulse; read CMD → 0.
- Pulse istatus_set=0x5, IRQ_EN=0x4 → STATUS reads 0x5, oirq=1; W1C 0x4 same cycle as istatus_set bit2 → bit2 stays 1; later W1C 0x4 alone → STATUS 0x1, oirq 0.
- Read iaddr=BASE_ADDR+6+NUM_SCRATCH and iaddr<BASE_ADDR → odata 0, ohit 0; write there → no register changes.
- Force TICK to all-ones via long run/preload → wraps to 0; write TICK concurrently with increment → reads 0 next cycle; assert irst mid-iwr → CTRL 0, re-commit after release.
